// File: rtl/rm_sequence_tracker.sv
// Tracks each monitor lane through the ordered detector events 0..NUM_EVENTS-1 and
// queues an alarm per completed lane onto a round-robin arbitrated valid/ready port.
module rm_sequence_tracker #(
    parameter int NUM_EVENTS     = 3,
    parameter int NUM_LANES      = 5,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int STRICT_ORDER   = 0,
    parameter int CNT_W          = 8,
    localparam int LW            = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     enable_i,
    input  logic [NUM_EVENTS-1:0]    evt_probe_i,
    input  logic [NUM_EVENTS*LW-1:0] evt_lane_i,
    input  logic [NUM_EVENTS-1:0]    evt_reset_i,
    output logic                     alarm_valid_o,
    output logic [LW-1:0]            alarm_lane_o,
    input  logic                     alarm_ready_i,
    output logic [NUM_LANES-1:0]     busy_o,
    output logic [CNT_W-1:0]         drop_cnt_o,
    output logic [CNT_W-1:0]         timeout_cnt_o
);

    localparam int SW = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;
    localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);
    localparam bit STRICT  = (STRICT_ORDER != 0);
    localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_EVENTS - 1);
    localparam logic [WW-1:0] WDOG_LAST  = WDOG_EN ? WW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [SW-1:0]        stage_q [NUM_LANES];
    logic [SW-1:0]        stage_d [NUM_LANES];
    logic [WW-1:0]        wdog_q  [NUM_LANES];
    logic [WW-1:0]        wdog_d  [NUM_LANES];
    logic [NUM_LANES-1:0] pending_q, pending_d;
    logic                 valid_q, valid_d;
    logic [LW-1:0]        rr_q, rr_d;
    logic [CNT_W-1:0]     drop_q, drop_d;
    logic [CNT_W-1:0]     tout_q, tout_d;

    logic [NUM_LANES-1:0] rst_hit_s, adv_hit_s, bad_hit_s, set_pend_s;
    logic                 load_s, gnt_vld_s;
    logic [LW-1:0]        gnt_lane_s;

    function automatic logic [LW-1:0] wrap_lane(input int unsigned v);
        return LW'(v % NUM_LANES);
    endfunction

    // Decode which detector slices address each lane and classify the hit.
    always_comb begin
        rst_hit_s = '0;
        adv_hit_s = '0;
        bad_hit_s = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int e = 0; e < NUM_EVENTS; e++) begin
                rst_hit_s[l] = rst_hit_s[l] |
                    ((evt_lane_i[e*LW +: LW] == LW'(l)) & evt_reset_i[e]);
                adv_hit_s[l] = adv_hit_s[l] |
                    ((evt_lane_i[e*LW +: LW] == LW'(l)) & evt_probe_i[e] &
                     (stage_q[l] == SW'(e)));
                bad_hit_s[l] = bad_hit_s[l] |
                    ((evt_lane_i[e*LW +: LW] == LW'(l)) & evt_probe_i[e] &
                     (stage_q[l] != SW'(e)));
            end
        end
    end

    // Round-robin pick of the first pending lane after the last granted one.
    always_comb begin
        load_s     = !valid_q || alarm_ready_i;
        gnt_vld_s  = 1'b0;
        gnt_lane_s = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (!gnt_vld_s && pending_q[wrap_lane(32'(rr_q) + 32'(i) + 32'd1)]) begin
                gnt_vld_s  = 1'b1;
                gnt_lane_s = wrap_lane(32'(rr_q) + 32'(i) + 32'd1);
            end else begin
                gnt_vld_s  = gnt_vld_s;
            end
        end
    end

    // Per-lane sequence progress, watchdog and the two saturating counters.
    always_comb begin
        drop_d     = drop_q;
        tout_d     = tout_q;
        set_pend_s = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            stage_d[l] = stage_q[l];
            wdog_d[l]  = wdog_q[l];
            if (!enable_i || rst_hit_s[l]) begin
                stage_d[l] = '0;
                wdog_d[l]  = '0;
            end else if (adv_hit_s[l]) begin
                wdog_d[l] = '0;
                if (stage_q[l] == LAST_STAGE) begin
                    stage_d[l]    = '0;
                    set_pend_s[l] = 1'b1;
                    // A pending bit leaving for the output this cycle makes room.
                    if (pending_q[l] && !(load_s && gnt_vld_s && (gnt_lane_s == LW'(l)))) begin
                        drop_d = (drop_d != CNT_MAX) ? drop_d + CNT_W'(1) : drop_d;
                    end else begin
                        drop_d = drop_d;
                    end
                end else begin
                    stage_d[l] = stage_q[l] + SW'(1);
                end
            end else if (STRICT && bad_hit_s[l] && (stage_q[l] != '0)) begin
                stage_d[l] = '0;
                wdog_d[l]  = '0;
            end else if (stage_q[l] != '0) begin
                if (WDOG_EN && (wdog_q[l] == WDOG_LAST)) begin
                    stage_d[l] = '0;
                    wdog_d[l]  = '0;
                    tout_d     = (tout_d != CNT_MAX) ? tout_d + CNT_W'(1) : tout_d;
                end else begin
                    wdog_d[l]  = wdog_q[l] + WW'(1);
                end
            end else begin
                wdog_d[l] = wdog_q[l];
            end
        end
    end

    // Pending set/clear and alarm register load; a re-completion keeps the bit set.
    always_comb begin
        pending_d = pending_q | set_pend_s;
        valid_d   = valid_q;
        rr_d      = rr_q;
        if (load_s) begin
            valid_d = gnt_vld_s;
            if (gnt_vld_s) begin
                rr_d                  = gnt_lane_s;
                pending_d[gnt_lane_s] = set_pend_s[gnt_lane_s];
            end else begin
                rr_d = rr_q;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                stage_q[l] <= '0;
                wdog_q[l]  <= '0;
            end
            pending_q <= '0;
            valid_q   <= 1'b0;
            rr_q      <= '0;
            drop_q    <= '0;
            tout_q    <= '0;
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                stage_q[l] <= stage_d[l];
                wdog_q[l]  <= wdog_d[l];
            end
            pending_q <= pending_d;
            valid_q   <= valid_d;
            rr_q      <= rr_d;
            drop_q    <= drop_d;
            tout_q    <= tout_d;
        end
    end

    // The last granted lane doubles as the presented alarm lane.
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            busy_o[l] = (stage_q[l] != '0);
        end
        alarm_valid_o = valid_q;
        alarm_lane_o  = rr_q;
        drop_cnt_o    = drop_q;
        timeout_cnt_o = tout_q;
    end

endmodule

// File: tb/tb_rm_sequence_tracker.sv
// Directed bench: a table of per-cycle vectors plus hand-written multi-cycle sequences,
// driving a relaxed-order/watchdog instance and a strict/no-watchdog instance in parallel.
module tb_rm_sequence_tracker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [2:0] probe;
    logic [5:0] lanes;
    logic [2:0] lrst;
    logic       ready;

    logic       valid_a, valid_b;
    logic [1:0] lane_a, lane_b;
    logic [3:0] busy_a, busy_b;
    logic [7:0] drop_a, tout_a;
    logic [1:0] drop_b, tout_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rm_sequence_tracker #(.NUM_EVENTS(3), .NUM_LANES(4), .TIMEOUT_CYCLES(4),
                          .STRICT_ORDER(0), .CNT_W(8)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .evt_probe_i(probe),
        .evt_lane_i(lanes), .evt_reset_i(lrst), .alarm_valid_o(valid_a),
        .alarm_lane_o(lane_a), .alarm_ready_i(ready), .busy_o(busy_a),
        .drop_cnt_o(drop_a), .timeout_cnt_o(tout_a));

    rm_sequence_tracker #(.NUM_EVENTS(3), .NUM_LANES(4), .TIMEOUT_CYCLES(0),
                          .STRICT_ORDER(1), .CNT_W(2)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .evt_probe_i(probe),
        .evt_lane_i(lanes), .evt_reset_i(lrst), .alarm_valid_o(valid_b),
        .alarm_lane_o(lane_b), .alarm_ready_i(ready), .busy_o(busy_b),
        .drop_cnt_o(drop_b), .timeout_cnt_o(tout_b));

    typedef struct packed {
        logic [2:0] probe;
        logic [1:0] lane;
        logic [2:0] rst;
        logic       ready;
        logic [3:0] exp_busy;
        logic       exp_valid;
        logic [1:0] exp_lane;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] p, input logic [1:0] ln, input logic [2:0] r);
        probe = p;
        lanes = {ln, ln, ln};
        lrst  = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic complete_lane(input logic [1:0] ln);
        drive(3'b001, ln, 3'b000); tick();
        drive(3'b010, ln, 3'b000); tick();
        drive(3'b100, ln, 3'b000); tick();
        drive(3'b000, 2'd0, 3'b000);
    endtask

    initial begin
        // probe, lane, rst, ready, busy, valid, alarm lane (state seen in that row's cycle)
        tbl[0]  = '{3'b000, 2'd0, 3'b000, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[1]  = '{3'b001, 2'd2, 3'b000, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[2]  = '{3'b000, 2'd0, 3'b000, 1'b1, 4'b0100, 1'b0, 2'd0};
        tbl[3]  = '{3'b010, 2'd2, 3'b000, 1'b1, 4'b0100, 1'b0, 2'd0};
        tbl[4]  = '{3'b000, 2'd0, 3'b000, 1'b1, 4'b0100, 1'b0, 2'd0};
        tbl[5]  = '{3'b100, 2'd2, 3'b000, 1'b1, 4'b0100, 1'b0, 2'd0};
        tbl[6]  = '{3'b000, 2'd0, 3'b000, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[7]  = '{3'b000, 2'd0, 3'b000, 1'b1, 4'b0000, 1'b1, 2'd2};
        tbl[8]  = '{3'b000, 2'd0, 3'b000, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[9]  = '{3'b001, 2'd1, 3'b000, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[10] = '{3'b010, 2'd1, 3'b000, 1'b1, 4'b0010, 1'b0, 2'd0};
        tbl[11] = '{3'b100, 2'd1, 3'b001, 1'b1, 4'b0010, 1'b0, 2'd0};
        tbl[12] = '{3'b000, 2'd0, 3'b000, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[13] = '{3'b000, 2'd0, 3'b000, 1'b1, 4'b0000, 1'b0, 2'd0};

        rst_n  = 1'b0;
        enable = 1'b1;
        ready  = 1'b1;
        drive(3'b000, 2'd0, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {31'd0, valid_a}, 32'd0);
        chk("reset_lane", {30'd0, lane_a}, 32'd0);
        chk("reset_busy", {28'd0, busy_a}, 32'd0);
        chk("reset_drop", {24'd0, drop_a}, 32'd0);
        chk("reset_tout", {24'd0, tout_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Ordered sequence on lane 2, then reset beating a completion on lane 1.
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].probe, tbl[i].lane, tbl[i].rst);
            ready = tbl[i].ready;
            chk($sformatf("tbl%0d_busy", i), {28'd0, busy_a}, {28'd0, tbl[i].exp_busy});
            chk($sformatf("tbl%0d_valid", i), {31'd0, valid_a}, {31'd0, tbl[i].exp_valid});
            if (tbl[i].exp_valid)
                chk($sformatf("tbl%0d_lane", i), {30'd0, lane_a}, {30'd0, tbl[i].exp_lane});
            tick();
        end

        // Round robin: lane 2 presented, lanes 0 and 3 pending -> 3 is served before 0.
        ready = 1'b0;
        complete_lane(2'd2);
        complete_lane(2'd0);
        complete_lane(2'd3);
        tick();
        chk("rr_hold_valid", {31'd0, valid_a}, 32'd1);
        chk("rr_hold_lane", {30'd0, lane_a}, 32'd2);
        ready = 1'b1;
        tick();
        chk("rr_first_valid", {31'd0, valid_a}, 32'd1);
        chk("rr_first_lane", {30'd0, lane_a}, 32'd3);
        tick();
        chk("rr_second_valid", {31'd0, valid_a}, 32'd1);
        chk("rr_second_lane", {30'd0, lane_a}, 32'd0);
        tick();
        chk("rr_drained", {31'd0, valid_a}, 32'd0);

        // Back-pressure: lane 1 completes three times, one alarm held, one dropped.
        ready = 1'b0;
        complete_lane(2'd1);
        complete_lane(2'd1);
        complete_lane(2'd1);
        tick();
        chk("bp_valid", {31'd0, valid_a}, 32'd1);
        chk("bp_lane", {30'd0, lane_a}, 32'd1);
        chk("bp_drop_a", {24'd0, drop_a}, 32'd1);
        chk("bp_drop_b", {30'd0, drop_b}, 32'd1);
        for (int i = 0; i < 3; i++) complete_lane(2'd1);
        chk("bp_stable_lane", {30'd0, lane_a}, 32'd1);
        chk("bp_drop_a4", {24'd0, drop_a}, 32'd4);
        chk("bp_drop_b_sat", {30'd0, drop_b}, 32'd3);
        ready = 1'b1;
        tick();
        chk("bp_pending_valid", {31'd0, valid_a}, 32'd1);
        chk("bp_pending_lane", {30'd0, lane_a}, 32'd1);
        tick();
        chk("bp_drained", {31'd0, valid_a}, 32'd0);

        // Completion in the same cycle its pending bit moves to the output: no drop.
        ready = 1'b0;
        complete_lane(2'd2);
        complete_lane(2'd1);
        drive(3'b001, 2'd1, 3'b000); tick();
        drive(3'b010, 2'd1, 3'b000); tick();
        drive(3'b100, 2'd1, 3'b000);
        ready = 1'b1;
        tick();
        drive(3'b000, 2'd0, 3'b000);
        chk("cc_lane1_first", {30'd0, lane_a}, 32'd1);
        chk("cc_valid_first", {31'd0, valid_a}, 32'd1);
        chk("cc_no_drop", {24'd0, drop_a}, 32'd4);
        tick();
        chk("cc_lane1_again", {30'd0, lane_a}, 32'd1);
        chk("cc_valid_again", {31'd0, valid_a}, 32'd1);
        tick();
        chk("cc_drained", {31'd0, valid_a}, 32'd0);

        // Watchdog: lane 0 parked at stage 1 is abandoned after 4 cycles.
        drive(3'b001, 2'd0, 3'b000);
        tick();
        drive(3'b000, 2'd0, 3'b000);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wd_busy%0d", i), {31'd0, busy_a[0]}, 32'd1);
            tick();
        end
        chk("wd_abort_busy", {31'd0, busy_a[0]}, 32'd0);
        chk("wd_tout_a", {24'd0, tout_a}, 32'd1);
        chk("wd_off_busy_b", {31'd0, busy_b[0]}, 32'd1);
        chk("wd_off_tout_b", {30'd0, tout_b}, 32'd0);
        drive(3'b000, 2'd0, 3'b001);
        tick();
        drive(3'b000, 2'd0, 3'b000);
        chk("lane_reset_b", {31'd0, busy_b[0]}, 32'd0);

        // Strict order: out-of-order e2 on lane 3 at stage 1.
        drive(3'b001, 2'd3, 3'b000); tick();
        drive(3'b100, 2'd3, 3'b000); tick();
        drive(3'b000, 2'd0, 3'b000);
        chk("strict_reset_b", {31'd0, busy_b[3]}, 32'd0);
        chk("relaxed_keep_a", {31'd0, busy_a[3]}, 32'd1);
        drive(3'b010, 2'd2, 3'b000); tick();
        drive(3'b000, 2'd0, 3'b000);
        chk("stage0_ignore_b", {31'd0, busy_b[2]}, 32'd0);
        chk("stage0_ignore_a", {31'd0, busy_a[2]}, 32'd0);

        // Disable clears progress and ignores probes.
        drive(3'b001, 2'd0, 3'b000); tick();
        chk("en_busy", {31'd0, busy_a[0]}, 32'd1);
        enable = 1'b0;
        drive(3'b010, 2'd0, 3'b000); tick();
        chk("dis_clear", {28'd0, busy_a}, 32'd0);
        drive(3'b001, 2'd1, 3'b000); tick();
        chk("dis_ignore", {28'd0, busy_b}, 32'd0);
        enable = 1'b1;
        drive(3'b000, 2'd0, 3'b000);

        // Asynchronous reset while an alarm is presented and a lane is mid-sequence.
        ready = 1'b0;
        complete_lane(2'd2);
        drive(3'b001, 2'd1, 3'b000);
        tick();
        drive(3'b000, 2'd0, 3'b000);
        chk("pre_rst_valid", {31'd0, valid_a}, 32'd1);
        chk("pre_rst_busy", {31'd0, busy_a[1]}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, valid_a}, 32'd0);
        chk("arst_busy", {28'd0, busy_a}, 32'd0);
        chk("arst_drop", {24'd0, drop_a}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
